// File: rtl/wl_pkg.sv
// Shared types and constants for the weight loader: FSM state encoding,
// error codes and the flush-to-data gap length.
package wl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    WAIT_TGT = 3'd2,
    FLUSH    = 3'd3,
    GAP      = 3'd4,
    SEND     = 3'd5,
    DONE     = 3'd6
  } wl_state_e;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_SIZE   = 3'd1;
  localparam logic [2:0] ERR_LOCKED = 3'd2;
  localparam logic [2:0] ERR_PROTO  = 3'd3;

  // Cycles between the flush pulse and the first kernel word (target dummy slot).
  localparam int WL_GAP_CYCLES = 1;

endpackage

// File: rtl/weight_loader_if.sv
// Bus bundle for the weight loader: upstream valid/ready stream plus the
// target weight-buffer write side. master = loader, slave = environment.
interface weight_loader_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  tgt_busy;
  logic                  tgt_unconfiged;
  logic                  flush_kernel;
  logic [DATA_WIDTH-1:0] wt_data;

  modport master (
    input  s_valid, s_data, tgt_busy, tgt_unconfiged,
    output s_ready, flush_kernel, wt_data
  );

  modport slave (
    output s_valid, s_data, tgt_busy, tgt_unconfiged,
    input  s_ready, flush_kernel, wt_data
  );

endinterface

// File: rtl/wl_stage_ram.sv
// Staging register file: one synchronous write port, one asynchronous read port.
module wl_stage_ram #(
  parameter  int DATA_WIDTH   = 16,
  parameter  int BUFFER_DEPTH = 16,
  localparam int AW           = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

  // Capture one upstream word per accepted handshake.
  // NOTE: the array has no reset; every word read is written during FILL first,
  // so a reset would only cost flops and a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_loader.sv
// Weight loader: collects one kernel from an upstream stream, then writes it to
// an idle, unconfigured PE weight buffer as flush / gap / K data words / done.
// Optional target-response monitor: define WEIGHT_LOADER_CHECK_EN.
module weight_loader
  import wl_pkg::*;
#(
  parameter  int DATA_WIDTH   = 16,
  parameter  int BUFFER_DEPTH = 16,
  localparam int AW           = $clog2(BUFFER_DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_start,
  input  logic [7:0]          kernel_size,
  weight_loader_if.master     bus,
  output logic                loader_busy,
  output logic                done,
  output logic [2:0]          err
);

  wl_state_e             state;
  logic [7:0]            ks;
  logic [7:0]            count;
  logic [7:0]            idx;
  logic [7:0]            gap_cnt;
  logic                  flush_q;
  logic                  done_q;
  logic [2:0]            err_q;
  logic [DATA_WIDTH-1:0] wt_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  s_ready;
  logic                  wr_en;
  logic [AW-1:0]         raddr;
`ifdef WEIGHT_LOADER_CHECK_EN
  logic                  proto_q;
`endif

  assign s_ready = (state == FILL) && (count < ks);
  assign wr_en   = bus.s_valid && s_ready;
  // Prefetch the next word so wt_data can be a registered output.
  assign raddr   = (state == SEND) ? AW'(idx + 8'd1) : '0;

  wl_stage_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(AW'(count)),
    .wdata(bus.s_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Main control FSM with registered flush/data/done/error outputs.
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ks      <= '0;
      count   <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_NONE;
      wt_q    <= '0;
`ifdef WEIGHT_LOADER_CHECK_EN
      proto_q <= 1'b0;
`endif
    end else begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_NONE;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            ks <= kernel_size;
            if (kernel_size == 8'd0 || kernel_size > 8'(BUFFER_DEPTH)) begin
              err_q <= ERR_SIZE;
            end else begin
              count <= '0;
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (wr_en) begin
            count <= count + 8'd1;
            if (count + 8'd1 == ks) state <= WAIT_TGT;
          end
        end
        WAIT_TGT: begin
          if (!bus.tgt_unconfiged) begin
            err_q <= ERR_LOCKED;
            state <= IDLE;
          end else if (!bus.tgt_busy) begin
            flush_q <= 1'b1;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          gap_cnt <= '0;
          state   <= GAP;
`ifdef WEIGHT_LOADER_CHECK_EN
          proto_q <= 1'b0;
`endif
        end
        GAP: begin
`ifdef WEIGHT_LOADER_CHECK_EN
          if (!bus.tgt_busy) proto_q <= 1'b1;
`endif
          if (gap_cnt == 8'(WL_GAP_CYCLES - 1)) begin
            idx   <= '0;
            wt_q  <= rdata;
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        SEND: begin
          if (idx == ks - 8'd1) begin
`ifdef WEIGHT_LOADER_CHECK_EN
            if (!bus.tgt_busy) proto_q <= 1'b1;
`endif
            wt_q   <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx  <= idx + 8'd1;
            wt_q <= rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Error output; the DONE-cycle busy check must see the live target response.
  // NOTE: err gets a default before any conditional override so no latch is inferred.
  always_comb begin
    err = err_q;
`ifdef WEIGHT_LOADER_CHECK_EN
    if (state == DONE && (proto_q || bus.tgt_busy)) err = ERR_PROTO;
`endif
  end

  assign bus.s_ready      = s_ready;
  assign bus.flush_kernel = flush_q;
  assign bus.wt_data      = wt_q;
  assign done             = done_q;
  assign loader_busy      = (state != IDLE);

endmodule

// File: tb/tb_weight_loader.sv
// Directed testbench for weight_loader: nominal load, upstream stalls, bad
// sizes, locked target, busy wait with mid-send reset, and target checker.
module tb_weight_loader;
  import wl_pkg::*;

  logic       clk;
  logic       rstn;
  logic       cfg_start;
  logic [7:0] kernel_size;
  logic       loader_busy;
  logic       done;
  logic [2:0] err;

  int n_chk;
  int n_fail;
  int flush_cnt;
  int done_cnt;

  weight_loader_if #(.DATA_WIDTH(16)) bus ();

  weight_loader #(.DATA_WIDTH(16), .BUFFER_DEPTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_start  (cfg_start),
    .kernel_size(kernel_size),
    .bus        (bus),
    .loader_busy(loader_busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count flush and done pulses seen by the target side.
  always @(posedge clk) begin
    if (bus.flush_kernel) flush_cnt <= flush_cnt + 1;
    if (done)             done_cnt  <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] k);
    cfg_start   = 1'b1;
    kernel_size = k;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({bus.flush_kernel, done, loader_busy, bus.s_ready, err, bus.wt_data} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got flush=%0b done=%0b busy=%0b rdy=%0b err=%0d wt=%h, want all 0",
               bus.flush_kernel, done, loader_busy, bus.s_ready, err, bus.wt_data);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_nominal;
    start(8'd9);
    n_chk++;
    if (loader_busy !== 1'b1 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_fill_entry: got busy=%0b rdy=%0b, want 1 1", loader_busy, bus.s_ready);
    end
    for (int i = 0; i < 9; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0101 + 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    n_chk++;
    if (bus.s_ready !== 1'b0 || bus.flush_kernel !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_after_fill: got rdy=%0b flush=%0b, want 0 0", bus.s_ready, bus.flush_kernel);
    end
    tick();  // T0
    n_chk++;
    if (bus.flush_kernel !== 1'b1 || bus.wt_data !== 16'h0) begin
      n_fail++;
      $display("FAIL nom_T0: got flush=%0b wt=%h, want 1 0000", bus.flush_kernel, bus.wt_data);
    end
    tick();  // T1
    bus.tgt_busy = 1'b1;
    n_chk++;
    if (bus.flush_kernel !== 1'b0 || bus.wt_data !== 16'h0) begin
      n_fail++;
      $display("FAIL nom_T1: got flush=%0b wt=%h, want 0 0000", bus.flush_kernel, bus.wt_data);
    end
    for (int i = 0; i < 9; i++) begin
      tick();  // T2..T10
      n_chk++;
      if (bus.wt_data !== 16'h0101 + 16'(i) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL nom_word%0d: got wt=%h done=%0b, want %h 0", i, bus.wt_data, done,
                 16'h0101 + 16'(i));
      end
    end
    tick();  // T11
    bus.tgt_busy = 1'b0;
    #1;
    n_chk++;
    if (done !== 1'b1 || bus.wt_data !== 16'h0 || err !== ERR_NONE) begin
      n_fail++;
      $display("FAIL nom_done: got done=%0b wt=%h err=%0d, want 1 0000 0", done, bus.wt_data, err);
    end
    tick();
    n_chk++;
    if (done !== 1'b0 || loader_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_idle: got done=%0b busy=%0b, want 0 0", done, loader_busy);
    end
  endtask

  task automatic test_stalls;
    logic [6:0]  pat;
    logic [15:0] exp_w [4];
    pat = 7'b1011001;  // pat[0..6] = 1,0,0,1,1,0,1
    exp_w[0] = 16'h0A00; exp_w[1] = 16'h0A03; exp_w[2] = 16'h0A04; exp_w[3] = 16'h0A06;
    bus.tgt_busy = 1'b1;  // hold the loader in WAIT_TGT after filling
    start(8'd4);
    for (int i = 0; i < 7; i++) begin
      bus.s_valid = pat[i];
      bus.s_data  = 16'h0A00 + 16'(i);
      n_chk++;
      if (bus.s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_ready%0d: got %0b, want 1", i, bus.s_ready);
      end
      tick();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0BAD;
    n_chk++;
    if (bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fifth: got s_ready=%0b, want 0", bus.s_ready);
    end
    tick();
    bus.s_valid = 1'b0;
    bus.tgt_busy = 1'b0;
    tick();  // T0
    n_chk++;
    if (bus.flush_kernel !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_flush: got %0b, want 1", bus.flush_kernel);
    end
    tick();  // T1
    bus.tgt_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (bus.wt_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL stall_word%0d: got %h, want %h", i, bus.wt_data, exp_w[i]);
      end
    end
    tick();
    bus.tgt_busy = 1'b0;
    #1;
    n_chk++;
    if (done !== 1'b1 || bus.wt_data !== 16'h0) begin
      n_fail++;
      $display("FAIL stall_done: got done=%0b wt=%h, want 1 0000", done, bus.wt_data);
    end
    tick();
  endtask

  task automatic test_bad_size;
    logic [7:0] sizes [2];
    int         f0;
    sizes[0] = 8'd0;
    sizes[1] = 8'd17;
    f0 = flush_cnt;
    for (int i = 0; i < 2; i++) begin
      start(sizes[i]);
      n_chk++;
      if (err !== ERR_SIZE || bus.s_ready !== 1'b0 || loader_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_size_%0d: got err=%0d rdy=%0b busy=%0b, want 1 0 0", sizes[i], err,
                 bus.s_ready, loader_busy);
      end
      tick();
      n_chk++;
      if (err !== ERR_NONE) begin
        n_fail++;
        $display("FAIL bad_size_pulse_%0d: got err=%0d, want 0", sizes[i], err);
      end
    end
    n_chk++;
    if (flush_cnt !== f0) begin
      n_fail++;
      $display("FAIL bad_size_flush: got %0d flushes, want %0d", flush_cnt, f0);
    end
  endtask

  task automatic test_locked;
    int f0;
    f0 = flush_cnt;
    bus.tgt_unconfiged = 1'b0;
    start(8'd3);
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0300 + 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    tick();
    n_chk++;
    if (err !== ERR_LOCKED || loader_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL locked_err: got err=%0d busy=%0b, want 2 0", err, loader_busy);
    end
    tick();
    n_chk++;
    if (err !== ERR_NONE || flush_cnt !== f0) begin
      n_fail++;
      $display("FAIL locked_after: got err=%0d flushes=%0d, want 0 %0d", err, flush_cnt, f0);
    end
    bus.tgt_unconfiged = 1'b1;
  endtask

  task automatic test_busy_reset;
    int f0;
    int d0;
    bus.tgt_busy = 1'b1;
    start(8'd4);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0C01 + 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (bus.flush_kernel !== 1'b0 || loader_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_wait%0d: got flush=%0b busy=%0b, want 0 1", i, bus.flush_kernel,
                 loader_busy);
      end
      tick();
    end
    bus.tgt_busy = 1'b0;
    tick();  // T0
    n_chk++;
    if (bus.flush_kernel !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_flush: got %0b, want 1", bus.flush_kernel);
    end
    tick();  // T1
    bus.tgt_busy = 1'b1;
    tick();  // T2
    tick();  // T3
    n_chk++;
    if (bus.wt_data !== 16'h0C02) begin
      n_fail++;
      $display("FAIL busy_T3_word: got %h, want 0c02", bus.wt_data);
    end
    f0 = flush_cnt;
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({bus.flush_kernel, done, loader_busy, bus.s_ready, err, bus.wt_data} !== 23'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got flush=%0b done=%0b busy=%0b rdy=%0b err=%0d wt=%h, want all 0",
               bus.flush_kernel, done, loader_busy, bus.s_ready, err, bus.wt_data);
    end
    tick();
    tick();
    rstn = 1'b1;
    bus.tgt_busy = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_chk++;
    if (done_cnt !== d0 || flush_cnt !== f0 || loader_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL postreset_quiet: got dones=%0d flushes=%0d busy=%0b, want %0d %0d 0",
               done_cnt, flush_cnt, loader_busy, d0, f0);
    end
  endtask

  task automatic test_checker;
    logic [2:0] exp_err;
`ifdef WEIGHT_LOADER_CHECK_EN
    exp_err = ERR_PROTO;
`else
    exp_err = ERR_NONE;
`endif
    bus.tgt_busy = 1'b0;
    start(8'd2);
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0D01 + 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    tick();  // T0
    tick();  // T1
    tick();  // T2
    tick();  // T3
    tick();  // T4 = DONE
    n_chk++;
    if (done !== 1'b1 || err !== exp_err) begin
      n_fail++;
      $display("FAIL checker_done: got done=%0b err=%0d, want 1 %0d", done, err, exp_err);
    end
    tick();
    n_chk++;
    if (err !== ERR_NONE) begin
      n_fail++;
      $display("FAIL checker_pulse: got err=%0d, want 0", err);
    end
  endtask

  initial begin
    n_chk              = 0;
    n_fail             = 0;
    flush_cnt          = 0;
    done_cnt           = 0;
    rstn               = 1'b1;
    cfg_start          = 1'b0;
    kernel_size        = 8'd0;
    bus.s_valid        = 1'b0;
    bus.s_data         = 16'h0;
    bus.tgt_busy       = 1'b0;
    bus.tgt_unconfiged = 1'b1;
    #2;
    test_reset();
    test_nominal();
    test_stalls();
    test_bad_size();
    test_locked();
    test_busy_reset();
    test_checker();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Transmit side of the PE weight-buffer load interface.
- Collects one kernel of weights from an upstream valid/ready stream (DMA/AXIS bridge) into a local staging buffer.
- When the kernel is complete and the target weight buffer is unconfigured and idle, it issues a one-cycle flush, a one-cycle gap, then the kernel words on consecutive cycles with no stalls. The receiver has no back-pressure.
- Sits between the weight DMA and one PE's weight buffer.

Parameters:
- DATA_WIDTH, 16: weight word width.
- BUFFER_DEPTH, 16: staging capacity in words; must equal the target buffer depth.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_start  in  1  pulse; begin loading one kernel.
- kernel_size  in  8  number of words K; sampled on an accepted cfg_start.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_WIDTH  upstream weight word.
- tgt_busy  in  1  target kernel_busy.
- tgt_unconfiged  in  1  target un_configed.
- flush_kernel  out  1  target write-start pulse.
- wt_data  out  DATA_WIDTH  word driven to target data_in.
- loader_busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the kernel has been sent.
- err  out  3  one-cycle error code: 1 = bad size, 2 = target locked, 3 = protocol (optional feature only).

Behaviour:
- Reset values: all outputs 0; state IDLE; count 0; staging buffer contents don't-care. Reset mid-operation aborts immediately; no flush is emitted after rstn releases.
- Stored size register ks is 8 bits. Counters count/idx are 8 bits; compare against ks only.
- IDLE:
  - cfg_start samples kernel_size into ks.
  - If ks==0 or ks>BUFFER_DEPTH: err=1 for one cycle, stay in IDLE.
  - Otherwise go to FILL with count=0.
- FILL:
  - s_ready = (count<ks).
  - Handshake s_valid&&s_ready writes buf[count]<=s_data and increments count.
  - When the accepting handshake makes count==ks, the next state is WAIT_TGT; s_ready falls that same next cycle.
  - Words offered after K are not accepted (s_ready=0).
- WAIT_TGT:
  - tgt_unconfiged=0: err=2 pulse, return to IDLE, kernel discarded.
  - tgt_unconfiged=1 and tgt_busy=0: go to FLUSH.
  - Otherwise wait.
- FLUSH (cycle T0): flush_kernel=1, wt_data=0.
- GAP (T1): flush_kernel=0, wt_data=0. The target is in its dummy write slot here.
- SEND (T2..T(K+1)): wt_data=buf[idx], idx 0..K-1, one word per cycle with no gaps. After idx==K-1, go to DONE.
- DONE (T(K+2)): done=1, wt_data=0, then IDLE.
- Total cycles from FLUSH to done: K+2. The target asserts busy over T1..T(K+1).
- cfg_start outside IDLE is ignored. Between sends, wt_data is held at 0 in every state except SEND.
- loader_busy is combinationally derived from the state.
- Simultaneous cfg_start with the DONE cycle is ignored (the state is not yet IDLE).

Optional Feature:
- Macro: WEIGHT_LOADER_CHECK_EN.
- Compiled in: monitors the target response.
  - tgt_busy must be 1 at T1 and at T(K+1), and 0 at T(K+2).
  - Any mismatch gives err=3 for one cycle in DONE; done still pulses.
- Compiled out: tgt_busy is used only in WAIT_TGT, and err never takes value 3.

Decomposition:
- Shared package wl_pkg:
  - state encoding localparams: IDLE, FILL, WAIT_TGT, FLUSH, GAP, SEND, DONE;
  - error codes ERR_NONE=0, ERR_SIZE=1, ERR_LOCKED=2, ERR_PROTO=3;
  - gap length constant WL_GAP_CYCLES=1.
- One natural sub-module: wl_stage_ram, a BUFFER_DEPTH x DATA_WIDTH register file with one write port and an asynchronous read port. The FSM stays in weight_loader.

Test Plan:
- Nominal load:
  - Stimulus: K=9, target unconfigured, upstream words 0x0101..0x0109 back-to-back.
  - Response: flush_kernel at T0; wt_data=0 at T1; 0x0101..0x0109 at T2..T10; done at T11; target buffer[0..8] matches.
- Upstream stalls:
  - Stimulus: K=4, s_valid toggling 1,0,0,1,1,0,1.
  - Response: exactly 4 words captured in order; s_ready=0 after the 4th; a 5th offered word is not accepted.
- Bad size:
  - Stimulus: cfg_start with kernel_size=0, then with kernel_size=17 (BUFFER_DEPTH=16).
  - Response: err=1 each time; no s_ready, no flush.
- Target locked:
  - Stimulus: K=3 filled, tgt_unconfiged=0.
  - Response: err=2 for one cycle, return to IDLE, flush_kernel never asserted.
- Wait on busy plus reset:
  - Stimulus: tgt_busy=1 for 5 cycles after fill; then rstn pulsed low at T3 of SEND.
  - Response: flush is delayed until busy=0; after reset all outputs are 0, state IDLE, no done.
- Checker (CHECK_EN):
  - Stimulus: K=2; model holds tgt_busy=0 throughout.
  - Response: err=3 in the DONE cycle.
